// File: rtl/ahfp_addsub_pipe_pkg.sv
// Shared definitions for the ahfp_* arithmetic blocks: operand classes and
// a helper that classifies a field-decoded operand.
package ahfp_addsub_pipe_pkg;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } op_class_t;

  // Denormals (exp==0) are treated as zero throughout the ahfp family.
  function automatic op_class_t classify(input logic exp_zero,
                                         input logic exp_ones,
                                         input logic frac_zero);
    if (exp_zero) return CLS_ZERO;
    if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/ahfp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module ahfp_lzc #(
  parameter int WIDTH = 27,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count
);

  // Scanning upward lets the highest set bit win the final assignment.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/ahfp_addsub_pipe.sv
// Pipelined floating-point adder/subtractor with a multi-cycle
// custom-instruction handshake: operand capture, align, add, normalise/round.
module ahfp_addsub_pipe
  import ahfp_addsub_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   start,
  input  logic                   n,
  input  logic [EXP_W+MAN_W:0]   dataa,
  input  logic [EXP_W+MAN_W:0]   datab,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   done
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 4;
  localparam int SW  = MAN_W + 5;
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(MW + 1);
  localparam logic [EXP_W-1:0]        SHIFT_MAX = EXP_W'(MAN_W + 3);
  localparam logic signed [EW-1:0]    EXP_MAX_S = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [W-1:0] a_q, b_q;
  logic         n_q;
  logic [2:0]   vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      n_q <= 1'b0;
      vld <= '0;
    end else if (clk_en) begin
      vld <= {vld[1:0], start};
      if (start) begin
        a_q <= dataa;
        b_q <= datab;
        n_q <= n;
      end
    end
  end

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  op_class_t        ca, cb;

  assign sa = a_q[W-1];
  assign sb = b_q[W-1] ^ n_q;
  assign ea = a_q[W-2:MAN_W];
  assign eb = b_q[W-2:MAN_W];
  assign fa = a_q[MAN_W-1:0];
  assign fb = b_q[MAN_W-1:0];
  assign ca = classify(ea == '0, ea == '1, fa == '0);
  assign cb = classify(eb == '0, eb == '1, fb == '0);

  logic             sign_big, sign_small, spec;
  logic [EXP_W-1:0] e_big, e_small, d;
  logic [MW-1:0]    m_big, m_small, m_shift, m_aligned;
  logic [W-1:0]     spec_val;
  logic             a_big, lost;

  // Flushed zeros carry no hidden bit so they align and add as true zeros.
  always_comb begin
    a_big = ((ca == CLS_ZERO) ? '0 : a_q[W-2:0]) >= ((cb == CLS_ZERO) ? '0 : b_q[W-2:0]);
    if (a_big) begin
      sign_big   = sa;
      sign_small = sb;
      e_big      = ea;
      e_small    = eb;
      m_big      = (ca == CLS_ZERO) ? '0 : {1'b1, fa, 3'b000};
      m_small    = (cb == CLS_ZERO) ? '0 : {1'b1, fb, 3'b000};
    end else begin
      sign_big   = sb;
      sign_small = sa;
      e_big      = eb;
      e_small    = ea;
      m_big      = (cb == CLS_ZERO) ? '0 : {1'b1, fb, 3'b000};
      m_small    = (ca == CLS_ZERO) ? '0 : {1'b1, fa, 3'b000};
    end
    d       = e_big - e_small;
    m_shift = m_small >> d;
    lost    = |(m_small & ~({MW{1'b1}} << d));
    if (d >= SHIFT_MAX) m_aligned = {{(MW-1){1'b0}}, |m_small};
    else                m_aligned = {m_shift[MW-1:1], m_shift[0] | lost};

    spec     = 1'b0;
    spec_val = '0;
    if (ca == CLS_NAN || cb == CLS_NAN || (ca == CLS_INF && cb == CLS_INF && sa != sb)) begin
      spec     = 1'b1;
      spec_val = QNAN;
    end else if (ca == CLS_INF) begin
      spec     = 1'b1;
      spec_val = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cb == CLS_INF) begin
      spec     = 1'b1;
      spec_val = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  logic             s1_sign_big, s1_sign_small, s1_spec;
  logic [EXP_W-1:0] s1_exp;
  logic [MW-1:0]    s1_mbig, s1_msmall;
  logic [W-1:0]     s1_spec_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_sign_big   <= 1'b0;
      s1_sign_small <= 1'b0;
      s1_exp        <= '0;
      s1_mbig       <= '0;
      s1_msmall     <= '0;
      s1_spec       <= 1'b0;
      s1_spec_val   <= '0;
    end else if (clk_en) begin
      s1_sign_big   <= sign_big;
      s1_sign_small <= sign_small;
      s1_exp        <= e_big;
      s1_mbig       <= m_big;
      s1_msmall     <= m_aligned;
      s1_spec       <= spec;
      s1_spec_val   <= spec_val;
    end
  end

  logic             s2_sign, s2_eff_sub, s2_spec;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0]    s2_sum;
  logic [W-1:0]     s2_spec_val;

  // Operands are magnitude-ordered, so the difference never goes negative.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_sign     <= 1'b0;
      s2_eff_sub  <= 1'b0;
      s2_exp      <= '0;
      s2_sum      <= '0;
      s2_spec     <= 1'b0;
      s2_spec_val <= '0;
    end else if (clk_en) begin
      s2_sign     <= s1_sign_big;
      s2_eff_sub  <= s1_sign_big ^ s1_sign_small;
      s2_exp      <= s1_exp;
      s2_sum      <= (s1_sign_big ^ s1_sign_small) ? ({1'b0, s1_mbig} - {1'b0, s1_msmall})
                                                   : ({1'b0, s1_mbig} + {1'b0, s1_msmall});
      s2_spec     <= s1_spec;
      s2_spec_val <= s1_spec_val;
    end
  end

  logic [LZW-1:0]         lz;
  logic [MW-1:0]          norm;
  logic signed [EW-1:0]   exp_n, exp_r;
  logic                   round_up;
  logic [MAN_W+1:0]       rounded;
  logic [MAN_W-1:0]       frac;
  logic [W-1:0]           res;

  ahfp_lzc #(.WIDTH(MW), .CW(LZW)) u_lzc (
    .value (s2_sum[MW-1:0]),
    .count (lz)
  );

  always_comb begin
    if (s2_sum[SW-1]) begin
      norm  = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
      exp_n = $signed({2'b00, s2_exp}) + EW'(1);
    end else begin
      norm  = s2_sum[MW-1:0] << lz;
      exp_n = $signed({2'b00, s2_exp}) - $signed({{(EW-LZW){1'b0}}, lz});
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[MW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    if (rounded[MAN_W+1]) begin
      exp_r = exp_n + EW'(1);
      frac  = rounded[MAN_W:1];
    end else begin
      exp_r = exp_n;
      frac  = rounded[MAN_W-1:0];
    end

    if (s2_spec)                res = s2_spec_val;
    else if (s2_sum == '0)      res = {s2_eff_sub ? 1'b0 : s2_sign, {(W-1){1'b0}}};
    else if (exp_r <= EW'(0))   res = {s2_sign, {(W-1){1'b0}}};
    else if (exp_r >= EXP_MAX_S) res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else                        res = {s2_sign, exp_r[EXP_W-1:0], frac};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      done   <= 1'b0;
    end else if (clk_en) begin
      done <= vld[2];
      if (vld[2]) result <= res;
    end
  end

endmodule

// File: doc/ahfp_addsub_pipe.md
Name: ahfp_addsub_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor with a Nios II multi-cycle custom-instruction handshake.
- Successor to the team's combinational positive-only adder. Adds signed operands, a subtract mode, full leading-zero normalisation, round-to-nearest-even and special-value handling.
- Three enabled stages. Accepts one operation per enabled cycle.
- Sits in the custom-instruction slot beside the other ahfp_* arithmetic blocks.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
- MAN_W, 23, stored fraction width (hidden bit not stored)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clk_en  in  1  pipeline advance enable; low freezes every register
- start  in  1  operation request, sampled when clk_en=1
- n  in  1  mode: 0 = dataa+datab, 1 = dataa-datab
- dataa  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}
- datab  in  1+EXP_W+MAN_W  operand B
- result  out  1+EXP_W+MAN_W  registered sum/difference
- done  out  1  result valid strobe

Behaviour:
- Reset:
  - result=0, done=0, all stage valid bits=0.
  - Reset mid-operation discards in-flight ops; no done pulse follows for them.
- Handshake and timing:
  - start with clk_en=1 at edge k launches an op.
  - done=1 and result valid after the 3rd subsequent enabled edge. With clk_en held high, done is high in the cycle following edge k+3.
  - done is exactly one enabled cycle wide per start.
  - Back-to-back starts give back-to-back done pulses.
  - clk_en=0 holds all stage registers, valid bits, done and result unchanged.
- result holds its last value while done=0.
- Stage 1 (unpack/align):
  - For subtract, invert B's sign.
  - Exp==0 operand is flushed to signed zero (denormals not supported).
  - Order operands by magnitude: larger goes in the big path.
  - Right-shift the small mantissa (with hidden bit) by the exponent difference, keeping guard, round and sticky bits.
  - Shift >= MAN_W+3 leaves sticky only.
  - Capture the special-case flags.
- Stage 2 (add):
  - Equal signs: add mantissas (MAN_W+5 bits incl. carry).
  - Otherwise subtract the small mantissa from the big one. Result sign = sign of the larger magnitude.
- Stage 3 (normalise/round/pack):
  - Carry out: shift right 1 and exponent+1; the shifted-out bit ORs into sticky.
  - Otherwise left-shift by the leading-zero count and subtract it from the exponent.
  - Round to nearest, ties to even, using G/R/S. A rounding carry renormalises (exponent+1).
- Boundary cases:
  - Exact cancellation gives +0. (-0)+(-0) gives -0.
  - Result exponent <= 0 after normalise flushes to signed zero.
  - Exponent >= all-ones gives signed infinity (exp all ones, frac 0).
  - Any NaN input, or inf-inf with effective subtraction, gives canonical qNaN {0, all-ones, 1 followed by zeros}.
  - Infinity plus a finite value gives that infinity.
- No internal state beyond the pipeline: no FSM. Control is a 3-bit valid shift register gated by clk_en.

Decomposition:
- Shared include file ahfp_defs.vh:
  - field-extract macros (sign/exp/frac positions from EXP_W, MAN_W)
  - EXP_MAX constant, BIAS constant, QNAN constant
  - special-case flag encoding (zero, inf, nan)
- Sub-module ahfp_lzc: parametrised combinational leading-zero counter (input width MAN_W+4, output clog2 width), used in stage 3. It is reusable by the future multiplier/divider.

Test Plan:
- clk_en=1, start once, dataa=0x3F800000, datab=0x3F800000, n=0 -> done high in the cycle after the 3rd edge, result=0x40000000, done low the next cycle.
- 0x3F800000 + 0xBF400000 (1.0 + -0.75), n=0 -> 0x3E800000. Then 0x3FC00000 - 0x3FC00000 with n=1 -> 0x00000000.
- Rounding:
  - 0x3F800000 + 0x33800000 (tie, even) -> 0x3F800000.
  - 0x3F800001 + 0x33800000 (tie, odd) -> 0x3F800002.
  - 0x3F800000 + 0x00000001 (denormal flushed) -> 0x3F800000.
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - 0x7F800000 - 0x7F800000 with n=1 -> 0x7FC00000.
  - 0xFF800000 + 0x3F800000 -> 0xFF800000.
- Throughput/stall:
  - 4 consecutive starts -> 4 consecutive done pulses in order.
  - Drop clk_en for 2 cycles mid-stream -> done/result frozen, order and values preserved.
- Reset: assert reset with 2 ops in flight -> done=0 and result=0 immediately (asynchronous). No done pulses after release. A new op completes normally.
